mips_branch_pc_unit: RTL
========================

# mips_branch_pc_unit

Program-counter and control-transfer unit for the Harvard MIPS CPU, a parametrised successor to the single-instruction BEQ path. It owns `instr_address` and decodes every MIPS-I branch and jump: BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL, J, JAL, JR and JALR. It implements the architectural branch delay slot, which can be switched off by parameter, and it drives the `active` halt flag. It sits between the instruction port and the register file, taking `rs` and `rt` read data from the datapath.

## Interface
- `ADDR_W`, default 32: PC width. Legal range is 28..32.
- `RESET_VECTOR`, default 32'hBFC00000: PC value after reset, truncated to `ADDR_W` bits.
- `HALT_ADDR`, default 0: a control transfer to this address halts the CPU.
- `DELAY_SLOT`, default 1: 1 means the instruction after a branch always executes; 0 means the target is fetched on the very next cycle.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `clk_enable` in 1: when low, all state holds.
- `instr_readdata` in 32: instruction at `instr_address`, combinational.
- `rs_data` in 32: register file value for `instr[25:21]`.
- `rt_data` in 32: register file value for `instr[20:16]`.
- `instr_address` out `ADDR_W`: current PC.
- `active` out 1: high while executing, low once halted.
- `branch_taken` out 1: combinational; high for the cycle in which a taken transfer is decoded.
- `link_we` out 1: combinational register-file write enable for link instructions.
- `link_reg` out 5: link destination; 31, or `rd` for JALR.
- `link_data` out 32: return address, zero-extended from `ADDR_W`.

## Operation
- States:
  - RUN: normal sequencing.
  - DELAY: a taken target is held; only reachable when `DELAY_SLOT`=1.
  - HALTED: terminal until reset.
- Decode is gated by "executing", defined as `clk_enable` high and state not HALTED.
- Branch conditions, all on signed 32-bit values:
  - BEQ: rs==rt. BNE: rs!=rt.
  - BLEZ: rs<=0. BGTZ: rs>0.
  - BLTZ / BLTZAL: rs<0. BGEZ / BGEZAL: rs>=0.
  - J, JAL, JR and JALR are always taken.
- Targets, with all arithmetic modulo 2^`ADDR_W`:
  - Conditional branches: PC+4+(sext(imm16)<<2).
  - J and JAL: {(PC+4)[ADDR_W-1:28], instr[25:0], 2'b00}, truncated to `ADDR_W`.
  - JR and JALR: `rs_data[ADDR_W-1:0]`.
- Link instructions are BLTZAL, BGEZAL, JAL and JALR.
  - `link_we` is asserted when a link instruction is executing. It is asserted even when the AL-branch condition is false, per MIPS-I.
  - `link_data` is PC+8 when `DELAY_SLOT`=1, else PC+4.
- Next PC:
  - RUN with no taken transfer: PC+4.
  - RUN with a taken transfer and `DELAY_SLOT`=1: PC+4, latch the target, go to DELAY.
  - RUN with a taken transfer and `DELAY_SLOT`=0: PC becomes the target.
  - DELAY: PC becomes the latched target; return to RUN.
- Halt: on the edge where PC would be loaded with `HALT_ADDR` from a taken transfer, PC is loaded, `active` goes 0 and the state goes to HALTED.
- Transfer in a delay slot: a branch or jump decoded while in DELAY is ignored. `branch_taken` stays 0 and its target is discarded. `link_we` still follows the link rule.
- In HALTED: PC is frozen, and `branch_taken` and `link_we` are 0.

## Timing
- Reset values on the `reset` edge: `instr_address`=`RESET_VECTOR`, `active`=1, state RUN, latched target cleared.
- `reset` wins over `clk_enable`=0 and over any in-flight DELAY or HALTED state. A pending target is discarded.
- Latency:
  - PC advances one edge after the instruction is presented.
  - With `DELAY_SLOT`=1, the target appears on the second edge after the branch.
  - With `DELAY_SLOT`=0, the target appears on the first edge.
- When `clk_enable` is 0: PC, state and the latched target hold; `branch_taken`=0 and `link_we`=0.
- `branch_taken`, `link_we`, `link_reg` and `link_data` are combinational from `instr_readdata`, `rs_data`, `rt_data` and the state. They are valid before the edge that consumes them.
- `active` changes only on a clock edge.

## Test plan
- Reset, then 3 NOPs with `DELAY_SLOT`=1 -> `instr_address` reads BFC00000, BFC00004, BFC00008, BFC0000C; `active`=1.
- BEQ at BFC00008 with rs=rt=20 and imm=0x0080 -> `branch_taken`=1. Next PC is BFC0000C (delay slot), then BFC0020C. The same BEQ with rs=20, rt=0 gives BFC0000C, then BFC00010.
- BGEZAL at BFC00000 with rs=-1 (not taken) -> `link_we`=1, `link_reg`=31, `link_data`=BFC00008, PC sequence unchanged. BLTZ with rs=-1 and imm=-1 is taken, with target equal to the branch PC.
- JR with rs=0 -> after the delay slot, `instr_address`=0 and `active`=0. Later NOPs leave PC at 0; `reset` restores BFC00000 and `active`=1.
- `DELAY_SLOT`=0, J with target field 0x0000100 at BFC00000 -> next PC is B0000400 on the first edge. `clk_enable`=0 for 3 cycles mid-DELAY holds PC and the target, and the sequence resumes correctly.
- JALR rd=5 in a delay slot -> no redirect and `branch_taken`=0; `link_we`=1 with `link_reg`=5. Asserting `reset` during DELAY discards the target and PC becomes BFC00000.

Source files
------------

// File: rtl/mips_branch_pc_unit.sv
// mips_branch_pc_unit: MIPS-I PC/branch/jump unit with optional delay slot and halt; clk/reset/clk_enable, instr_readdata/rs_data/rt_data in; instr_address, active, branch_taken, link_we/link_reg/link_data out
module mips_branch_pc_unit #(
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h0,
  parameter bit          DELAY_SLOT   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic [31:0]       instr_readdata,
  input  logic [31:0]       rs_data,
  input  logic [31:0]       rt_data,
  output logic [ADDR_W-1:0] instr_address,
  output logic              active,
  output logic              branch_taken,
  output logic              link_we,
  output logic [4:0]        link_reg,
  output logic [31:0]       link_data
);
  localparam logic [1:0] RUN = 2'd0, DELAY = 2'd1, HALTED = 2'd2;
  logic [1:0] state;
  logic [ADDR_W-1:0] target_q, target, pc4;
  logic [3:0] seg;
  logic [5:0] op;
  logic exec, jr, jalr, jmp, regimm, bcond, xfer, link, cond, halt;
  assign op = instr_readdata[31:26];
  assign jr = op == 6'd0 && instr_readdata[5:0] == 6'd8;
  assign jalr = op == 6'd0 && instr_readdata[5:0] == 6'd9;
  assign jmp = op[5:1] == 5'd1;
  assign regimm = op == 6'd1 && instr_readdata[19:17] == 3'd0;
  assign bcond = op[5:2] == 4'd1;
  assign xfer = jr || jalr || jmp || regimm || bcond;
  assign link = jalr || (jmp && op[0]) || (regimm && instr_readdata[20]);
  assign cond = op == 6'd4 ? rs_data == rt_data :
                op == 6'd5 ? rs_data != rt_data :
                op == 6'd6 ? $signed(rs_data) <= 0 :
                op == 6'd7 ? $signed(rs_data) > 0 :
                regimm ? instr_readdata[16] ^ rs_data[31] : 1'b1;
  assign pc4 = instr_address + ADDR_W'(4);
  assign seg = 4'(32'(pc4) >> 28);
  assign target = jr || jalr ? rs_data[ADDR_W-1:0] :
                  jmp ? ADDR_W'({seg, instr_readdata[25:0], 2'b00}) :
                  pc4 + ADDR_W'({{14{instr_readdata[15]}}, instr_readdata[15:0], 2'b00});
  assign exec = clk_enable && state != HALTED;
  assign branch_taken = exec && state == RUN && xfer && cond;
  assign link_we = exec && link;
  assign link_reg = jalr ? instr_readdata[15:11] : 5'd31;
  assign link_data = 32'(instr_address + ADDR_W'(DELAY_SLOT ? 8 : 4));
  assign active = state != HALTED;
  // halting happens on the edge that actually loads HALT_ADDR into the PC
  assign halt = state == DELAY ? target_q == ADDR_W'(HALT_ADDR) :
                !DELAY_SLOT && branch_taken && target == ADDR_W'(HALT_ADDR);
  always_ff @(posedge clk)
    if (reset) begin
      instr_address <= ADDR_W'(RESET_VECTOR);
      state <= RUN;
      target_q <= '0;
    end else if (exec) begin
      instr_address <= state == DELAY ? target_q : branch_taken && !DELAY_SLOT ? target : pc4;
      state <= halt ? HALTED : branch_taken && DELAY_SLOT ? DELAY : RUN;
      target_q <= branch_taken ? target : target_q;
    end
endmodule
